// File: rtl/button_event.sv
`default_nettype none
// ============================================================================
// Module      : button_event
// Description : Turns a debounced button level into one-cycle press, release,
//               long-press and auto-repeat events plus a held level.
//               Auto-repeat is built only when BUTTON_EVENT_REPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic button_clean,
    input  logic enable,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_release,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LONG_TERM = CNT_W'(LONG_CYCLES - 1);

    // Empty marker block: appears in the hierarchy only if CNT_W is too narrow.
    if ((CNT_W < 64) && (((64'd1 << CNT_W) <= 64'(LONG_CYCLES)) ||
                         ((64'd1 << CNT_W) <= 64'(REPEAT_CYCLES)))) begin : g_cnt_w_too_narrow
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_prev_q, btn_prev_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             held_q, held_d;
    logic             w_rise, w_fall;

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] C_REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);
    logic             repeat_q, repeat_d;
`endif

    assign w_rise = button_clean & ~btn_prev_q;
    assign w_fall = ~button_clean & btn_prev_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        btn_prev_d = button_clean;
        press_d    = 1'b0;
        release_d  = 1'b0;
        short_d    = 1'b0;
        long_d     = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
        repeat_d   = 1'b0;
`endif

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (w_rise) begin
                        state_d = ST_PRESSED;
                        press_d = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // A fall beats the terminal count in the same cycle.
                    if (w_fall) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                        short_d   = 1'b1;
                    end else if (cnt_q == C_LONG_TERM) begin
                        state_d = ST_LONG;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else if (cnt_q < C_LONG_TERM) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_LONG: begin
                    if (w_fall) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
                        if (cnt_q == C_REPEAT_TERM) begin
                            cnt_d    = '0;
                            repeat_d = 1'b1;
                        end else if (cnt_q < C_REPEAT_TERM) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
`else
                        cnt_d = '0;
`endif
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        held_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            // Treat the button as already down so a hold through reset is ignored.
            btn_prev_q <= 1'b1;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            held_q     <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
            repeat_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            btn_prev_q <= btn_prev_d;
            press_q    <= press_d;
            release_q  <= release_d;
            short_q    <= short_d;
            long_q     <= long_d;
            held_q     <= held_d;
`ifdef BUTTON_EVENT_REPEAT_EN
            repeat_q   <= repeat_d;
`endif
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_release = short_q;
    assign long_pulse    = long_q;
    assign held          = held_q;
`ifdef BUTTON_EVENT_REPEAT_EN
    assign repeat_pulse  = repeat_q;
`else
    assign repeat_pulse  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_event.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event
// Description : Directed self-checking bench for button_event
//               (LONG_CYCLES=8, REPEAT_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event;

    localparam int C_LONG = 8;
    localparam int C_REP  = 4;
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam bit C_REP_EN = 1'b1;
`else
    localparam bit C_REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic button_clean;
    logic enable;
    logic press_pulse, release_pulse, short_release, long_pulse, repeat_pulse, held;
    logic [5:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    button_event #(
        .LONG_CYCLES   (C_LONG),
        .REPEAT_CYCLES (C_REP),
        .CNT_W         (4)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .button_clean  (button_clean),
        .enable        (enable),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_release (short_release),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    // {press, release, short, long, repeat, held}
    assign obs = {press_pulse, release_pulse, short_release, long_pulse, repeat_pulse, held};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; button_clean = 1'b0;
        tick(); tick();
        n_checks++;
        if (obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", obs, 6'b000000);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want %b", obs, 6'b000000);
        end
    endtask

    task automatic test_short_press();
        logic [5:0] exp_tab [6];
        exp_tab = '{6'b100001, 6'b000001, 6'b000001, 6'b011000, 6'b000000, 6'b000000};
        for (int i = 0; i < 6; i++) begin
            button_clean = (i < 3);
            tick();
            n_checks++;
            if (obs !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL short_press step %0d: got %b want %b", i, obs, exp_tab[i]);
            end
        end
    endtask

    task automatic test_long_repeat();
        logic [5:0] exp_v;
        for (int i = 0; i < 25; i++) begin
            button_clean = (i < 20);
            tick();
            exp_v = 6'b000000;
            if (i == 0) exp_v[5] = 1'b1;
            if (i == 20) exp_v[4] = 1'b1;
            if (i == C_LONG) exp_v[2] = 1'b1;
            if (C_REP_EN && i > C_LONG && i < 20 && ((i - C_LONG) % C_REP) == 0) exp_v[1] = 1'b1;
            if (i < 20) exp_v[0] = 1'b1;
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL long_repeat step %0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_tiebreak();
        logic [5:0] exp_v;
        for (int i = 0; i < 11; i++) begin
            button_clean = (i < C_LONG);
            tick();
            if (i == 0)           exp_v = 6'b100001;
            else if (i < C_LONG)  exp_v = 6'b000001;
            else if (i == C_LONG) exp_v = 6'b011000;
            else                  exp_v = 6'b000000;
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL tiebreak step %0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_gating();
        // {rst, enable, button, expected obs}
        logic [8:0] steps [20];
        steps = '{
            {3'b111, 6'b000000}, {3'b011, 6'b000000}, {3'b011, 6'b000000}, {3'b010, 6'b000000},
            {3'b011, 6'b100001}, {3'b010, 6'b011000}, {3'b001, 6'b000000}, {3'b001, 6'b000000},
            {3'b011, 6'b000000}, {3'b011, 6'b000000}, {3'b010, 6'b000000}, {3'b011, 6'b100001},
            {3'b011, 6'b000001}, {3'b111, 6'b000000}, {3'b011, 6'b000000}, {3'b010, 6'b000000},
            {3'b011, 6'b100001}, {3'b001, 6'b000000}, {3'b010, 6'b000000}, {3'b010, 6'b000000}
        };
        for (int i = 0; i < 20; i++) begin
            rst          = steps[i][8];
            enable       = steps[i][7];
            button_clean = steps[i][6];
            tick();
            n_checks++;
            if (obs !== steps[i][5:0]) begin
                n_fail++;
                $display("FAIL reset_gating step %0d: got %b want %b", i, obs, steps[i][5:0]);
            end
        end
        rst = 1'b0; enable = 1'b1; button_clean = 1'b0;
    endtask

    task automatic test_random();
        int bal = 0;
        int run = 0;
        logic [3:0] pulses;
        for (int i = 0; i < 10000; i++) begin
            if (run == 0) begin
                button_clean = ~button_clean;
                run = $urandom_range(1, 14);
            end
            run--;
            enable = ($urandom_range(0, 49) != 0);
            rst    = ($urandom_range(0, 199) == 0);
            tick();
            pulses = {press_pulse, release_pulse, long_pulse, repeat_pulse};
            n_checks++;
            if (!$onehot0(pulses)) begin
                n_fail++;
                $display("FAIL rand_onehot cycle %0d: got %b want one-hot-or-zero", i, pulses);
            end
            n_checks++;
            if (short_release && !release_pulse) begin
                n_fail++;
                $display("FAIL rand_short_implies_release cycle %0d: got short=%b release=%b", i, short_release, release_pulse);
            end
            if (rst || !enable) bal = 0;
            else bal = bal + int'(press_pulse) - int'(release_pulse);
            n_checks++;
            if (bal < 0 || bal > 1 || held !== (bal == 1)) begin
                n_fail++;
                $display("FAIL rand_balance cycle %0d: got bal=%0d held=%b want bal in 0..1 matching held", i, bal, held);
            end
        end
        rst = 1'b0; enable = 1'b1; button_clean = 1'b0;
        tick(); tick();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; button_clean = 1'b0;
        test_reset();
        test_short_press();
        test_long_repeat();
        tick();
        test_tiebreak();
        tick();
        test_reset_gating();
        tick();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
